// File: rtl/manchester_unframer.sv
// Flag-delimited frame recovery with byte unescaping.
// Emits payload as AXI-Stream through an output FIFO.
module manchester_unframer #(
  parameter logic [7:0] FLAG       = 8'h7E,
  parameter logic [7:0] ESC        = 8'h7D,
  parameter logic [7:0] ESC_XOR    = 8'h20,
  parameter int         FIFO_DEPTH = 16,
  parameter int         MAX_LEN    = 256
) (
  input  logic       aclk,
  input  logic       areset,
  input  logic [7:0] s_axis_tdata,
  input  logic       s_axis_tvalid,
  output logic [7:0] m_axis_tdata,
  output logic       m_axis_tvalid,
  input  logic       m_axis_tready,
  output logic       m_axis_tlast,
  output logic       m_axis_tuser,
  output logic       frame_err,
  output logic       overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int LW = $clog2(MAX_LEN + 1);

  typedef enum logic [1:0] {
    S_HUNT,
    S_SYNC,
    S_DATA,
    S_ESC
  } state_t;

  state_t          r_state;
  logic [7:0]      r_hold;
  logic            r_hold_vld;
  logic [LW-1:0]   r_len;
  logic [9:0]      r_mem [FIFO_DEPTH];
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [CW-1:0]   r_count;
  logic            r_err;
  logic            r_ovf;

  state_t          w_nstate;
  logic [7:0]      w_hold_d;
  logic            w_hvld_d;
  logic [LW-1:0]   w_len_d;
  logic            w_push;
  logic            w_plast;
  logic            w_puser;
  logic            w_err;
  logic            w_ovf;
  logic            w_data;
  logic            w_abort;
  logic [7:0]      w_dbyte;
  logic            w_pop;
  logic [CW-1:0]   w_free;
  logic            w_is_flag;
  logic            w_is_esc;
  logic            w_ovalid;

  assign w_is_flag = (s_axis_tdata == FLAG);
  assign w_is_esc  = (s_axis_tdata == ESC);
  assign w_ovalid  = (r_count != '0);
  assign w_pop     = w_ovalid & m_axis_tready;
  // space counted after a same-cycle pop
  assign w_free    = CW'(FIFO_DEPTH) - r_count + CW'(w_pop);

  // framing FSM: decode byte, decide pushes and pulses
  always_comb begin
    w_nstate = r_state;
    w_hold_d = r_hold;
    w_hvld_d = r_hold_vld;
    w_len_d  = r_len;
    w_push   = 1'b0;
    w_plast  = 1'b0;
    w_puser  = 1'b0;
    w_err    = 1'b0;
    w_ovf    = 1'b0;
    w_data   = 1'b0;
    w_abort  = 1'b0;
    w_dbyte  = s_axis_tdata;
    if (s_axis_tvalid) begin
      unique case (r_state)
        S_HUNT: begin
          if (w_is_flag) w_nstate = S_SYNC;
        end
        S_SYNC: begin
          if (w_is_esc) w_nstate = S_ESC;
          else if (!w_is_flag) w_data = 1'b1;
        end
        S_DATA: begin
          if (w_is_flag) begin
            w_hvld_d = 1'b0;
            w_len_d  = '0;
            if (w_free != '0) begin
              w_push   = 1'b1;
              w_plast  = 1'b1;
              w_nstate = S_SYNC;
            end else begin
              w_ovf    = 1'b1;
              w_nstate = S_HUNT;
            end
          end else if (w_is_esc) begin
            w_nstate = S_ESC;
          end else begin
            w_data = 1'b1;
          end
        end
        S_ESC: begin
          if (w_is_flag || w_is_esc) begin
            w_abort = 1'b1;
          end else begin
            w_data  = 1'b1;
            w_dbyte = s_axis_tdata ^ ESC_XOR;
          end
        end
        default: w_nstate = S_HUNT;
      endcase
    end
    // bad escape: close any open beat as a bad frame
    if (w_abort) begin
      w_err    = 1'b1;
      w_hvld_d = 1'b0;
      w_len_d  = '0;
      w_nstate = w_is_flag ? S_SYNC : S_HUNT;
      if (r_hold_vld) begin
        if (w_free != '0) begin
          w_push  = 1'b1;
          w_plast = 1'b1;
          w_puser = 1'b1;
        end else begin
          w_ovf    = 1'b1;
          w_nstate = S_HUNT;
        end
      end
    end
    // payload byte: shift through the hold register
    if (w_data) begin
      if (!r_hold_vld) begin
        w_hold_d = w_dbyte;
        w_hvld_d = 1'b1;
        w_len_d  = LW'(1);
        w_nstate = S_DATA;
      end else if (r_len == LW'(MAX_LEN)) begin
        w_err    = 1'b1;
        w_hvld_d = 1'b0;
        w_len_d  = '0;
        w_nstate = S_HUNT;
        if (w_free != '0) begin
          w_push  = 1'b1;
          w_plast = 1'b1;
          w_puser = 1'b1;
        end else begin
          w_ovf = 1'b1;
        end
      end else if (w_free >= CW'(2)) begin
        w_push   = 1'b1;
        w_hold_d = w_dbyte;
        w_len_d  = r_len + LW'(1);
        w_nstate = S_DATA;
      end else begin
        // keep one slot so the frame still ends on tlast
        w_ovf    = 1'b1;
        w_hvld_d = 1'b0;
        w_len_d  = '0;
        w_nstate = S_HUNT;
        if (w_free == CW'(1)) begin
          w_push  = 1'b1;
          w_plast = 1'b1;
          w_puser = 1'b1;
        end
      end
    end
  end

  // framing state, hold register and error pulses
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state    <= S_HUNT;
      r_hold     <= '0;
      r_hold_vld <= 1'b0;
      r_len      <= '0;
      r_err      <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      r_state    <= w_nstate;
      r_hold     <= w_hold_d;
      r_hold_vld <= w_hvld_d;
      r_len      <= w_len_d;
      r_err      <= w_err;
      r_ovf      <= w_ovf;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      if (w_push && !w_pop)      r_count <= r_count + CW'(1);
      else if (!w_push && w_pop) r_count <= r_count - CW'(1);
    end
  end

  // FIFO storage: {tuser, tlast, tdata}
  always_ff @(posedge aclk) begin
    if (w_push) r_mem[r_wptr] <= {w_puser, w_plast, r_hold};
  end

  assign m_axis_tvalid = w_ovalid;
  assign {m_axis_tuser, m_axis_tlast, m_axis_tdata} =
    w_ovalid ? r_mem[r_rptr] : 10'd0;
  assign frame_err = r_err;
  assign overflow  = r_ovf;

endmodule

// File: tb/tb_manchester_unframer.sv
// Directed bench for manchester_unframer.
// Three instances: default, FIFO_DEPTH=4, MAX_LEN=3.
module tb_manchester_unframer;

  logic       aclk;
  logic       areset;
  logic [7:0] s_tdata;
  logic       s_tvalid;
  logic       m_tready;

  logic [7:0] a_data, b_data, c_data;
  logic       a_vld, b_vld, c_vld;
  logic       a_last, b_last, c_last;
  logic       a_user, b_user, c_user;
  logic       a_err, b_err, c_err;
  logic       a_ovf, b_ovf, c_ovf;

  logic [9:0] q_a [$];
  logic [9:0] q_b [$];
  logic [9:0] q_c [$];
  int e_a, e_b, e_c;
  int o_a, o_b, o_c;

  int n_cmp;
  int n_bad;

  manchester_unframer u_a (
    .aclk(aclk), .areset(areset),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid),
    .m_axis_tdata(a_data), .m_axis_tvalid(a_vld),
    .m_axis_tready(m_tready), .m_axis_tlast(a_last),
    .m_axis_tuser(a_user), .frame_err(a_err), .overflow(a_ovf)
  );

  manchester_unframer #(.FIFO_DEPTH(4)) u_b (
    .aclk(aclk), .areset(areset),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid),
    .m_axis_tdata(b_data), .m_axis_tvalid(b_vld),
    .m_axis_tready(m_tready), .m_axis_tlast(b_last),
    .m_axis_tuser(b_user), .frame_err(b_err), .overflow(b_ovf)
  );

  manchester_unframer #(.MAX_LEN(3)) u_c (
    .aclk(aclk), .areset(areset),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid),
    .m_axis_tdata(c_data), .m_axis_tvalid(c_vld),
    .m_axis_tready(m_tready), .m_axis_tlast(c_last),
    .m_axis_tuser(c_user), .frame_err(c_err), .overflow(c_ovf)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // capture transfers and pulses away from the rising edge
  always @(negedge aclk) begin
    if (a_vld && m_tready) q_a.push_back({a_user, a_last, a_data});
    if (b_vld && m_tready) q_b.push_back({b_user, b_last, b_data});
    if (c_vld && m_tready) q_c.push_back({c_user, c_last, c_data});
    if (a_err) e_a++;
    if (b_err) e_b++;
    if (c_err) e_c++;
    if (a_ovf) o_a++;
    if (b_ovf) o_b++;
    if (c_ovf) o_c++;
  end

  task automatic clr();
    q_a.delete(); q_b.delete(); q_c.delete();
    e_a = 0; e_b = 0; e_c = 0;
    o_a = 0; o_b = 0; o_c = 0;
  endtask

  task automatic do_reset();
    s_tvalid = 1'b0;
    areset = 1'b1;
    @(posedge aclk); #1;
    areset = 1'b0;
    @(posedge aclk); #1;
    clr();
  endtask

  task automatic send(input logic [7:0] b);
    s_tdata  = b;
    s_tvalid = 1'b1;
    @(posedge aclk); #1;
    s_tvalid = 1'b0;
  endtask

  task automatic idle(input int n);
    s_tvalid = 1'b0;
    repeat (n) @(posedge aclk);
    #1;
  endtask

  task automatic test_reset();
    logic [11:0] got;
    s_tvalid = 1'b0;
    m_tready = 1'b0;
    areset = 1'b1;
    @(posedge aclk); #1;
    got = {a_vld, a_last, a_user, a_data, a_err, a_ovf};
    n_cmp++;
    if (got !== 12'd0) begin
      n_bad++;
      $display("FAIL reset_outs got %h want 000", got);
    end
    areset = 1'b0;
    @(posedge aclk); #1;
    got = {b_vld, b_last, b_user, b_data, b_err, b_ovf};
    n_cmp++;
    if (got !== 12'd0) begin
      n_bad++;
      $display("FAIL reset_outs_b got %h want 000", got);
    end
  endtask

  task automatic test_basic();
    logic [9:0] exp [3];
    logic [9:0] got;
    exp[0] = 10'h001; exp[1] = 10'h002; exp[2] = 10'h103;
    do_reset();
    m_tready = 1'b1;
    send(8'h7E);
    send(8'h01);
    n_cmp++;
    if (a_vld !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_hold_vld got %b want 0", a_vld);
    end
    send(8'h02);
    n_cmp++;
    if ({a_vld, a_data} !== 9'h101) begin
      n_bad++;
      $display("FAIL basic_latency got %h want 101", {a_vld, a_data});
    end
    send(8'h03);
    send(8'h7E);
    idle(4);
    n_cmp++;
    if (q_a.size() != 3) begin
      n_bad++;
      $display("FAIL basic_cnt got %0d want 3", q_a.size());
    end
    for (int i = 0; i < 3; i++) begin
      got = (i < q_a.size()) ? q_a[i] : 10'h3ff;
      n_cmp++;
      if (got !== exp[i]) begin
        n_bad++;
        $display("FAIL basic_beat%0d got %h want %h", i, got, exp[i]);
      end
    end
    n_cmp++;
    if ({e_a, o_a} != 64'd0) begin
      n_bad++;
      $display("FAIL basic_pulses got err=%0d ovf=%0d want 0", e_a, o_a);
    end
  endtask

  task automatic test_escape();
    logic [7:0] vec [7];
    logic [9:0] exp [3];
    logic [9:0] got;
    vec = '{8'h7E, 8'h7D, 8'h5E, 8'h41, 8'h7D, 8'h5D, 8'h7E};
    exp[0] = 10'h07E; exp[1] = 10'h041; exp[2] = 10'h17D;
    do_reset();
    m_tready = 1'b1;
    for (int i = 0; i < 7; i++) send(vec[i]);
    idle(4);
    n_cmp++;
    if (q_a.size() != 3) begin
      n_bad++;
      $display("FAIL esc_cnt got %0d want 3", q_a.size());
    end
    for (int i = 0; i < 3; i++) begin
      got = (i < q_a.size()) ? q_a[i] : 10'h3ff;
      n_cmp++;
      if (got !== exp[i]) begin
        n_bad++;
        $display("FAIL esc_beat%0d got %h want %h", i, got, exp[i]);
      end
    end
  endtask

  task automatic test_junk();
    logic [7:0] vec [8];
    logic [9:0] exp [2];
    logic [9:0] got;
    vec = '{8'h00, 8'h55, 8'h7E, 8'h11, 8'h7E, 8'h7E, 8'h22, 8'h7E};
    exp[0] = 10'h111; exp[1] = 10'h122;
    do_reset();
    m_tready = 1'b1;
    for (int i = 0; i < 8; i++) send(vec[i]);
    idle(4);
    n_cmp++;
    if (q_a.size() != 2) begin
      n_bad++;
      $display("FAIL junk_cnt got %0d want 2", q_a.size());
    end
    for (int i = 0; i < 2; i++) begin
      got = (i < q_a.size()) ? q_a[i] : 10'h3ff;
      n_cmp++;
      if (got !== exp[i]) begin
        n_bad++;
        $display("FAIL junk_beat%0d got %h want %h", i, got, exp[i]);
      end
    end
  endtask

  task automatic test_abort();
    logic [7:0] vec [6];
    logic [9:0] exp [2];
    logic [9:0] got;
    vec = '{8'h7E, 8'h10, 8'h7D, 8'h7E, 8'h20, 8'h7E};
    exp[0] = 10'h310; exp[1] = 10'h120;
    do_reset();
    m_tready = 1'b1;
    for (int i = 0; i < 6; i++) send(vec[i]);
    idle(4);
    n_cmp++;
    if (q_a.size() != 2) begin
      n_bad++;
      $display("FAIL abort_cnt got %0d want 2", q_a.size());
    end
    for (int i = 0; i < 2; i++) begin
      got = (i < q_a.size()) ? q_a[i] : 10'h3ff;
      n_cmp++;
      if (got !== exp[i]) begin
        n_bad++;
        $display("FAIL abort_beat%0d got %h want %h", i, got, exp[i]);
      end
    end
    n_cmp++;
    if (e_a != 1 || o_a != 0) begin
      n_bad++;
      $display("FAIL abort_pulses got err=%0d ovf=%0d want 1/0", e_a, o_a);
    end
  endtask

  task automatic test_overflow();
    logic [7:0] vec [11];
    logic [9:0] exp [4];
    logic [9:0] got;
    vec = '{8'h7E, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05,
            8'h06, 8'h7E, 8'h7E, 8'h09, 8'h7E};
    exp[0] = 10'h001; exp[1] = 10'h002;
    exp[2] = 10'h003; exp[3] = 10'h304;
    do_reset();
    m_tready = 1'b0;
    for (int i = 0; i < 11; i++) begin
      send(vec[i]);
      if (i == 5) begin
        n_cmp++;
        if (b_ovf !== 1'b1) begin
          n_bad++;
          $display("FAIL ovf_at_05 got %b want 1", b_ovf);
        end
      end
    end
    idle(2);
    n_cmp++;
    if (o_b != 2 || e_b != 0) begin
      n_bad++;
      $display("FAIL ovf_pulses got ovf=%0d err=%0d want 2/0", o_b, e_b);
    end
    n_cmp++;
    if ({b_vld, b_user, b_last, b_data} !== 11'h401) begin
      n_bad++;
      $display("FAIL ovf_stall_hold got %h want 401",
               {b_vld, b_user, b_last, b_data});
    end
    m_tready = 1'b1;
    idle(8);
    n_cmp++;
    if (q_b.size() != 4) begin
      n_bad++;
      $display("FAIL ovf_cnt got %0d want 4", q_b.size());
    end
    for (int i = 0; i < 4; i++) begin
      got = (i < q_b.size()) ? q_b[i] : 10'h3ff;
      n_cmp++;
      if (got !== exp[i]) begin
        n_bad++;
        $display("FAIL ovf_beat%0d got %h want %h", i, got, exp[i]);
      end
    end
  endtask

  task automatic test_oversize();
    logic [7:0] vec [8];
    logic [9:0] exp [4];
    logic [9:0] got;
    vec = '{8'h7E, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'h7E, 8'hB1, 8'h7E};
    exp[0] = 10'h0A1; exp[1] = 10'h0A2;
    exp[2] = 10'h3A3; exp[3] = 10'h1B1;
    do_reset();
    m_tready = 1'b1;
    for (int i = 0; i < 8; i++) send(vec[i]);
    idle(4);
    n_cmp++;
    if (q_c.size() != 4) begin
      n_bad++;
      $display("FAIL len_cnt got %0d want 4", q_c.size());
    end
    for (int i = 0; i < 4; i++) begin
      got = (i < q_c.size()) ? q_c[i] : 10'h3ff;
      n_cmp++;
      if (got !== exp[i]) begin
        n_bad++;
        $display("FAIL len_beat%0d got %h want %h", i, got, exp[i]);
      end
    end
    n_cmp++;
    if (e_c != 1 || o_c != 0) begin
      n_bad++;
      $display("FAIL len_pulses got err=%0d ovf=%0d want 1/0", e_c, o_c);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] vec [4];
    logic [9:0] got;
    vec = '{8'h33, 8'h7E, 8'h44, 8'h7E};
    do_reset();
    m_tready = 1'b0;
    send(8'h7E);
    send(8'h01);
    send(8'h02);
    areset = 1'b1;
    @(posedge aclk); #1;
    areset = 1'b0;
    n_cmp++;
    if ({a_vld, a_last, a_user, a_data} !== 11'd0) begin
      n_bad++;
      $display("FAIL rstmid_outs got %h want 000",
               {a_vld, a_last, a_user, a_data});
    end
    m_tready = 1'b1;
    for (int i = 0; i < 4; i++) send(vec[i]);
    idle(4);
    n_cmp++;
    if (q_a.size() != 1) begin
      n_bad++;
      $display("FAIL rstmid_cnt got %0d want 1", q_a.size());
    end
    got = (q_a.size() > 0) ? q_a[0] : 10'h3ff;
    n_cmp++;
    if (got !== 10'h144) begin
      n_bad++;
      $display("FAIL rstmid_beat got %h want 144", got);
    end
  endtask

  initial begin
    n_cmp    = 0;
    n_bad    = 0;
    s_tdata  = 8'h00;
    s_tvalid = 1'b0;
    m_tready = 1'b0;
    areset   = 1'b1;
    clr();
    repeat (2) @(posedge aclk);
    #1;
    test_reset();
    test_basic();
    test_escape();
    test_junk();
    test_abort();
    test_overflow();
    test_oversize();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
